// File: rtl/edge_pkg.sv
// Shared FSM state type, FIFO entry width and line-size helper for the edge frame packer.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // One FIFO entry is {tlast, byte}.
    localparam int ENTRY_W = 9;

    function automatic int BYTES_PER_LINE(input int h_res);
        return h_res / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head visible 1 clk after the write.
// Push on full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop    = pop_i & ~empty_o;
    // A simultaneous pop frees the slot, so a push at full still lands.
    assign do_push   = push_i & (~full_o | do_pop);
    assign pop_dat_o = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat_i;
    end

endmodule

// File: rtl/edge_frame_packer.sv
// Binarises one armed frame of edge pixels and packs 8 pixels per byte, MSB first, into an AXI-stream.
// Byte valid 2 clk after its 8th pixel; bytes pushed into a full FIFO are dropped and flagged.
module edge_frame_packer
    import edge_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int EDGE_TH    = 128,
    parameter int FIFO_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_de,
    input  logic [WIDTH-1:0] i_data,
    output logic [7:0]       o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_tlast,
    output logic             o_busy,
    output logic             o_overflow,
    output logic             o_frame_err
);

    localparam int LW = (V_RES > 1) ? $clog2(V_RES) : 1;

    state_e               state_q, state_d;
    logic                 vs_q, de_q;
    logic [7:0]           sh_q, sh_d, sh_ins;
    logic [2:0]           bit_q, bit_d;
    logic [LW-1:0]        line_q, line_d;
    logic                 push_q, push_d;
    logic [ENTRY_W-1:0]   push_dat_q, push_dat_d;
    logic                 ovf_q, ovf_d, ferr_q, ferr_d;

    logic                 vs_rise, de_fall, pix_bit, last_line, tag_last;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdat, fifo_dat;
    logic                 unused_cfg;

    // hsync and the line width play no part in the packing datapath.
    assign unused_cfg = ^{i_hsync, 32'(BYTES_PER_LINE(H_RES))};

    assign vs_rise   = i_vsync & ~vs_q;
    assign de_fall   = ~i_de & de_q;
    assign pix_bit   = (i_data >= WIDTH'(EDGE_TH));
    assign sh_ins    = sh_q | (8'(pix_bit) << (3'd7 - bit_q));
    assign last_line = (line_q == LW'(V_RES - 1));

    // A full last line completes its final byte the cycle before de falls, so that
    // byte is still on the push port when the line end is seen: tag it in flight.
    assign tag_last  = (state_q == CAPTURE) & de_fall & (bit_q == 3'd0) & last_line;
    assign fifo_wdat = {push_dat_q[8] | tag_last, push_dat_q[7:0]};
    assign fifo_pop  = ~fifo_empty & i_tready;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_d      = bit_q;
        line_d     = line_q;
        push_d     = 1'b0;
        push_dat_d = push_dat_q;
        ovf_d      = ovf_q | (push_q & fifo_full & ~fifo_pop);
        ferr_d     = ferr_q;
        case (state_q)
            IDLE: begin
                if (i_capture) begin
                    state_d = ARMED;
                    ovf_d   = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ARMED: begin
                if (vs_rise) begin
                    state_d = CAPTURE;
                    sh_d    = '0;
                    bit_d   = '0;
                    line_d  = '0;
                end
            end
            CAPTURE: begin
                if (vs_rise) begin
                    state_d = DRAIN;
                    ferr_d  = 1'b1;
                    sh_d    = '0;
                    bit_d   = '0;
                end else if (i_de) begin
                    if (bit_q == 3'd7) begin
                        push_d     = 1'b1;
                        push_dat_d = {1'b0, sh_ins};
                        sh_d       = '0;
                        bit_d      = '0;
                    end else begin
                        sh_d  = sh_ins;
                        bit_d = bit_q + 3'd1;
                    end
                end else if (de_fall) begin
                    if (bit_q != 3'd0) begin
                        push_d     = 1'b1;
                        push_dat_d = {last_line, sh_q};
                    end
                    sh_d  = '0;
                    bit_d = '0;
                    if (last_line) state_d = DRAIN;
                    else           line_d  = line_q + LW'(1);
                end
            end
            DRAIN: begin
                if (fifo_empty && !push_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            sh_q       <= '0;
            bit_q      <= '0;
            line_q     <= '0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= i_vsync;
            de_q       <= i_de;
            sh_q       <= sh_d;
            bit_q      <= bit_d;
            line_q     <= line_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    sync_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_q),
        .push_dat_i (fifo_wdat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Gate the head so stale memory is never visible while empty.
    assign o_tvalid    = ~fifo_empty;
    assign o_tdata     = fifo_empty ? 8'h00 : fifo_dat[7:0];
    assign o_tlast     = ~fifo_empty & fifo_dat[8];
    assign o_busy      = (state_q != IDLE);
    assign o_overflow  = ovf_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_edge_frame_packer.sv
// Randomised scoreboard bench for edge_frame_packer with a line-level packing model.
module tb_edge_frame_packer;
    import edge_pkg::*;

    localparam int WIDTH      = 8;
    localparam int H_RES      = 16;
    localparam int V_RES      = 2;
    localparam int EDGE_TH    = 128;
    localparam int FIFO_DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_capture = 1'b0;
    logic       i_vsync = 1'b0;
    logic       i_hsync = 1'b0;
    logic       i_de = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       i_tready = 1'b0;
    logic       o_tlast;
    logic       o_busy;
    logic       o_overflow;
    logic       o_frame_err;

    int         n_chk = 0;
    int         n_fail = 0;
    int         rx_cnt = 0;
    int         rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic [8:0] exp_q [$];
    int         line_px [$];

    always #5 clk = ~clk;

    edge_frame_packer #(
        .WIDTH      (WIDTH),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .EDGE_TH    (EDGE_TH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_capture   (i_capture),
        .i_vsync     (i_vsync),
        .i_hsync     (i_hsync),
        .i_de        (i_de),
        .i_data      (i_data),
        .o_tdata     (o_tdata),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_tlast     (o_tlast),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow),
        .o_frame_err (o_frame_err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_capture();
        i_capture = 1'b1;
        tick();
        i_capture = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_vsync = 1'b1;
        repeat (2) tick();
        i_vsync = 1'b0;
        repeat (2) tick();
    endtask

    // Expected bytes of one line: groups of 8 pixels, first pixel in bit 7, short group zero-filled.
    task automatic model_line(input bit last);
        int n;
        int nb;
        logic [7:0] v;
        n  = line_px.size();
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            v = 8'h00;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < n && line_px[b * 8 + j] >= EDGE_TH) v[7 - j] = 1'b1;
            exp_q.push_back({last && (b == nb - 1), v});
        end
    endtask

    task automatic drive_line(input bit expect_bytes, input bit last, input bit chk_lat);
        if (expect_bytes) model_line(last);
        foreach (line_px[i]) begin
            i_de    = 1'b1;
            i_hsync = 1'b1;
            i_data  = 8'(line_px[i]);
            if (chk_lat && i == 8) begin
                @(negedge clk);
                check("latency_early_vld", o_tvalid, 0);
            end
            if (chk_lat && i == 9) begin
                @(negedge clk);
                check("latency_2clk_vld", o_tvalid, 1);
            end
            tick();
        end
        i_de    = 1'b0;
        i_hsync = 1'b0;
        i_data  = 8'h00;
        repeat (4) tick();
    endtask

    task automatic fill_line(input int len, input int v0, input int v1);
        line_px.delete();
        for (int i = 0; i < len; i++) line_px.push_back((i % 2 == 0) ? v0 : v1);
    endtask

    task automatic rand_line();
        int len;
        int sel;
        line_px.delete();
        sel = $urandom_range(0, 2);
        len = (sel == 0) ? H_RES : (sel == 1) ? 8 : $urandom_range(1, H_RES);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) line_px.push_back($urandom_range(0, 1) ? 128 : 127);
            else                           line_px.push_back($urandom_range(0, 255));
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && o_busy; i++) tick();
        check({tag, "_busy_after_drain"}, o_busy, 0);
        repeat (3) tick();
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    task automatic monitor();
        logic       pv;
        logic       pr;
        logic [8:0] pd;
        logic [8:0] e;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr)
                    check("hold_stable", {o_tvalid, o_tlast, o_tdata}, {1'b1, pd});
                if (o_tvalid && i_tready) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %03h, none expected (t=%0t)",
                                 {o_tlast, o_tdata}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", {o_tlast, o_tdata}, e);
                    end
                end
                pv = o_tvalid;
                pr = i_tready;
                pd = {o_tlast, o_tdata};
            end
        end
    endtask

    task automatic rdy_drive();
        forever begin
            @(posedge clk);
            #1;
            i_tready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        int  base;
        int  nl;
        bit  early;
        fork
            monitor();
            rdy_drive();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_tlast", o_tlast, 0);
        check("rst_busy", o_busy, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_frame_err", o_frame_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Alternating 200/10 over two lines -> AA x4, tlast on the 4th
        rdy_mode = 1;
        base = rx_cnt;
        pulse_capture();
        tick();
        check("armed_busy", o_busy, 1);
        vsync_pulse();
        fill_line(H_RES, 200, 10);
        drive_line(1, 0, 1);
        drive_line(1, 1, 0);
        wait_idle("aa_frame");
        check("aa_frame_bytes", rx_cnt - base, BYTES_PER_LINE(H_RES) * V_RES);

        // Short line of 12 x 255 -> FF, F0; then a full random last line
        pulse_capture();
        tick();
        vsync_pulse();
        fill_line(12, 255, 255);
        drive_line(1, 0, 0);
        rand_line();
        drive_line(1, 1, 0);
        wait_idle("pad_frame");
        check("pad_frame_err", o_frame_err, 0);

        // Early vsync after one line -> frame error, no tlast
        pulse_capture();
        tick();
        vsync_pulse();
        fill_line(H_RES, 255, 0);
        drive_line(1, 0, 0);
        vsync_pulse();
        wait_idle("early_vs");
        check("early_vs_frame_err", o_frame_err, 1);

        // Stalled sink for a whole frame with a 2-entry FIFO -> overflow, only 2 bytes survive
        rdy_mode = 0;
        repeat (2) tick();
        pulse_capture();
        tick();
        check("capture_clears_ferr", o_frame_err, 0);
        vsync_pulse();
        fill_line(H_RES, 130, 5);
        drive_line(1, 0, 0);
        fill_line(H_RES, 7, 250);
        drive_line(1, 1, 0);
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        repeat (4) tick();
        check("ovf_set", o_overflow, 1);
        check("ovf_stuck_in_drain", o_busy, 1);
        pulse_capture();
        repeat (2) tick();
        check("ovf_capture_ignored_flag", o_overflow, 1);
        check("ovf_capture_ignored_busy", o_busy, 1);
        base = rx_cnt;
        rdy_mode = 1;
        wait_idle("ovf");
        check("ovf_bytes_delivered", rx_cnt - base, FIFO_DEPTH);

        // Reset in the middle of a line with a byte waiting in the FIFO
        rdy_mode = 0;
        repeat (2) tick();
        pulse_capture();
        tick();
        check("capture_clears_ovf", o_overflow, 0);
        vsync_pulse();
        for (int i = 0; i < 12; i++) begin
            i_de   = 1'b1;
            i_data = 8'hFF;
            tick();
        end
        check("pre_rst_tvalid", o_tvalid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tvalid", o_tvalid, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_tdata", o_tdata, 0);
        rdy_mode = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            i_de   = 1'b1;
            i_data = 8'hFF;
            tick();
        end
        i_de = 1'b0;
        repeat (3) tick();
        vsync_pulse();
        fill_line(H_RES, 255, 255);
        drive_line(0, 0, 0);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_tvalid", o_tvalid, 0);

        // Random frames under random backpressure; capture pulses mid-frame must be ignored
        for (int f = 0; f < 10; f++) begin
            nl    = $urandom_range(1, V_RES);
            early = (nl < V_RES);
            rdy_mode = 2;
            pulse_capture();
            tick();
            vsync_pulse();
            for (int l = 0; l < nl; l++) begin
                rand_line();
                drive_line(1, (l == V_RES - 1), 0);
                if (l == 0) pulse_capture();
            end
            if (early) vsync_pulse();
            wait_idle("rand");
            check("rand_frame_err", o_frame_err, early);
            check("rand_overflow", o_overflow, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
